// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and constants for the cache-line <-> burst adaptor.
//   LINE_W    : cache line width (bits)
//   BEAT_W    : memory burst beat width (bits)
//   BEATS     : beats per line (power of two)
//   LINE_MASK : clears the byte-offset bits of a line address
//   state_t   : adaptor FSM states
//   beat_idx_t: beat counter / buffer index
package cacheline_adaptor_pkg;
  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;
  localparam int BEATS  = LINE_W / BEAT_W;
  localparam int IDX_W  = $clog2(BEATS);

  localparam logic [31:0] LINE_MASK = ~32'(LINE_W / 8 - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [IDX_W-1:0] beat_idx_t;
endpackage

// File: rtl/cacheline_adaptor_if.sv
// Physical-memory burst bus. Signal names follow the adaptor's point of view.
//   burst_i   : read beat from memory
//   burst_o   : write beat to memory
//   address_o : line-aligned burst base address
//   read_o    : burst read request
//   write_o   : burst write request
//   resp_i    : memory beat valid / accept
// master = adaptor side, slave = memory side.
interface cacheline_adaptor_if;
  import cacheline_adaptor_pkg::*;
  logic [BEAT_W-1:0] burst_i;
  logic [BEAT_W-1:0] burst_o;
  logic [31:0]       address_o;
  logic              read_o;
  logic              write_o;
  logic              resp_i;

  modport master (input burst_i, resp_i, output burst_o, address_o, read_o, write_o);
  modport slave  (output burst_i, resp_i, input burst_o, address_o, read_o, write_o);
endinterface

// File: rtl/cacheline_adaptor_reg.sv
// Generic load-enable register with synchronous active-high reset.
//   clk, rst : clock / reset (reset clears to zero)
//   ld_i     : load enable
//   d_i      : next value
//   q_o      : registered value
module cacheline_adaptor_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  always_ff @(posedge clk) begin
    if (rst)       q_o <= '0;
    else if (ld_i) q_o <= d_i;
  end
endmodule

// File: rtl/cacheline_adaptor.sv
// Converts whole-line cache transfers into BEATS-beat bursts on the memory bus.
//   clk, rst  : clock, synchronous active-high reset
//   line_i    : write-back line from the cache
//   line_o    : assembled fill line to the cache (valid from DONE onward)
//   address_i : line address from the cache
//   read_i    : cache requests a fill
//   write_i   : cache requests a write-back (wins over read_i)
//   resp_o    : one-cycle completion pulse
//   mem       : burst bus (master side)
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,
  input  logic [31:0]       address_i,
  input  logic              read_i,
  input  logic              write_i,
  output logic              resp_o,
  cacheline_adaptor_if.master mem
);
  state_t    state_q;
  beat_idx_t cnt_q;
  logic      read_q, write_q, resp_q;
  // Separate buffers per direction so a write-back never disturbs line_o.
  logic [BEATS-1:0][BEAT_W-1:0] rbuf_q;
  logic [BEATS-1:0][BEAT_W-1:0] wbuf_q;

  logic        addr_ld;
  logic [31:0] addr_d, addr_q;

  assign addr_ld = (state_q == IDLE) && (read_i || write_i);
  assign addr_d  = address_i & LINE_MASK;

  cacheline_adaptor_reg #(.W(32)) u_addr (
    .clk  (clk),
    .rst  (rst),
    .ld_i (addr_ld),
    .d_i  (addr_d),
    .q_o  (addr_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
      rbuf_q  <= '0;
      wbuf_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          resp_q <= 1'b0;
          if (write_i) begin
            wbuf_q  <= line_i;
            cnt_q   <= '0;
            write_q <= 1'b1;
            state_q <= WRITE;
          end else if (read_i) begin
            cnt_q   <= '0;
            read_q  <= 1'b1;
            state_q <= READ;
          end
        end
        READ: begin
          if (mem.resp_i) begin
            rbuf_q[cnt_q] <= mem.burst_i;
            cnt_q         <= cnt_q + 1'b1;
            if (cnt_q == beat_idx_t'(BEATS - 1)) begin
              read_q  <= 1'b0;
              resp_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        WRITE: begin
          if (mem.resp_i) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == beat_idx_t'(BEATS - 1)) begin
              write_q <= 1'b0;
              resp_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        default: begin  // DONE: pulse already visible, back to IDLE
          resp_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign line_o        = rbuf_q;
  assign resp_o        = resp_q;
  assign mem.read_o    = read_q;
  assign mem.write_o   = write_q;
  assign mem.address_o = addr_q;
  // Beat select follows the counter directly; zero outside WRITE.
  assign mem.burst_o   = (state_q == WRITE) ? wbuf_q[cnt_q] : '0;
endmodule

// File: tb/tb_cacheline_adaptor.sv
module tb_cacheline_adaptor;
  import cacheline_adaptor_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [LINE_W-1:0] line_i, line_o;
  logic [31:0]       address_i;
  logic              read_i, write_i, resp_o;

  int checks = 0;
  int errors = 0;

  cacheline_adaptor_if mem_if ();

  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .mem       (mem_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [BEAT_W-1:0] bA, bB, bC, bD;
  logic              pat_r [7];
  logic [BEAT_W-1:0] pat_d [7];
  int                pulses;

  initial begin
    rst = 1'b1; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    mem_if.burst_i = '0; mem_if.resp_i = 1'b0;
    tick(); tick();
    // ---- reset state
    chk("rst_read_o",  mem_if.read_o, 0);
    chk("rst_write_o", mem_if.write_o, 0);
    chk("rst_resp_o",  resp_o, 0);
    chk("rst_addr_o",  mem_if.address_o, 0);
    chk("rst_burst_o", mem_if.burst_o, 0);
    chk("rst_line_o",  line_o, 0);
    chk("rst_state",   dut.state_q, IDLE);
    rst = 1'b0;
    tick();

    // ---- read, no stalls
    address_i = 32'h1234_567F; read_i = 1'b1;
    tick();
    chk("rd_read_o",  mem_if.read_o, 1);
    chk("rd_addr_o",  mem_if.address_o, 32'h1234_5660);
    for (int k = 0; k < 4; k++) begin
      chk("rd_no_early_resp", resp_o, 0);
      mem_if.resp_i = 1'b1; mem_if.burst_i = 64'(k);
      tick();
    end
    mem_if.resp_i = 1'b0;
    chk("rd_resp_o",   resp_o, 1);
    chk("rd_read_low", mem_if.read_o, 0);
    chk("rd_line_o",   line_o, {64'h3, 64'h2, 64'h1, 64'h0});
    read_i = 1'b0;
    tick();
    chk("rd_resp_single", resp_o, 0);
    chk("rd_idle",        dut.state_q, IDLE);
    chk("rd_line_hold",   line_o, {64'h3, 64'h2, 64'h1, 64'h0});

    // ---- read with stalls: 1,0,0,1,0,1,1
    bA = 64'hAAAA_0000_0000_000A; bB = 64'hBBBB_0000_0000_000B;
    bC = 64'hCCCC_0000_0000_000C; bD = 64'hDDDD_0000_0000_000D;
    pat_r = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    pat_d = '{bA, 64'hDEAD, 64'hBEEF, bB, 64'hF00D, bC, bD};
    address_i = 32'h0000_8000; read_i = 1'b1;
    tick();
    pulses = 0;
    for (int k = 0; k < 7; k++) begin
      mem_if.resp_i = pat_r[k]; mem_if.burst_i = pat_d[k];
      tick();
      if (resp_o) pulses++;
    end
    mem_if.resp_i = 1'b0;
    chk("st_resp_now", resp_o, 1);
    chk("st_pulses",   pulses, 1);
    chk("st_line_o",   line_o, {bD, bC, bB, bA});
    read_i = 1'b0;
    tick();
    chk("st_resp_drop", resp_o, 0);

    // ---- write
    line_i = {{4{16'hDDDD}}, {4{16'hCCCC}}, {4{16'hBBBB}}, {4{16'hAAAA}}};
    address_i = 32'hCAFE_0021; write_i = 1'b1;
    tick();
    chk("wr_write_o", mem_if.write_o, 1);
    chk("wr_addr_o",  mem_if.address_o, 32'hCAFE_0020);
    chk("wr_beat0",   mem_if.burst_o, {4{16'hAAAA}});
    mem_if.resp_i = 1'b1;
    tick();
    chk("wr_beat1", mem_if.burst_o, {4{16'hBBBB}});
    tick();
    chk("wr_beat2", mem_if.burst_o, {4{16'hCCCC}});
    tick();
    chk("wr_beat3", mem_if.burst_o, {4{16'hDDDD}});
    chk("wr_no_early_resp", resp_o, 0);
    tick();
    mem_if.resp_i = 1'b0;
    chk("wr_resp_o",    resp_o, 1);
    chk("wr_write_low", mem_if.write_o, 0);
    chk("wr_line_o_untouched", line_o, {bD, bC, bB, bA});
    write_i = 1'b0;
    tick();
    chk("wr_resp_drop", resp_o, 0);

    // ---- write-back then fill (both requests held)
    line_i = {64'h4, 64'h3, 64'h2, 64'h1};
    address_i = 32'h0000_1000; write_i = 1'b1; read_i = 1'b1;
    pulses = 0;
    tick();
    chk("wf_write_first", {mem_if.write_o, mem_if.read_o}, 2'b10);
    mem_if.resp_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (resp_o) pulses++;
    end
    mem_if.resp_i = 1'b0;
    chk("wf_wr_resp", resp_o, 1);
    write_i = 1'b0; address_i = 32'h0000_203F;
    tick();
    chk("wf_idle_gap", {mem_if.write_o, mem_if.read_o, resp_o}, 3'b000);
    tick();
    chk("wf_read_o",  mem_if.read_o, 1);
    chk("wf_rd_addr", mem_if.address_o, 32'h0000_2020);
    for (int k = 0; k < 4; k++) begin
      mem_if.resp_i = 1'b1; mem_if.burst_i = 64'h11 * 64'(k + 1);
      tick();
      if (resp_o) pulses++;
    end
    mem_if.resp_i = 1'b0;
    chk("wf_pulses", pulses, 2);
    chk("wf_line_o", line_o, {64'h44, 64'h33, 64'h22, 64'h11});
    read_i = 1'b0;
    tick();

    // ---- reset mid-burst
    address_i = 32'h0000_4000; read_i = 1'b1;
    tick();
    mem_if.resp_i = 1'b1;
    mem_if.burst_i = 64'h99; tick();
    mem_if.burst_i = 64'h98; tick();
    mem_if.resp_i = 1'b0; rst = 1'b1;
    tick();
    chk("mr_outs", {mem_if.read_o, mem_if.write_o, resp_o}, 3'b000);
    chk("mr_addr", mem_if.address_o, 0);
    chk("mr_line", line_o, 0);
    chk("mr_state", dut.state_q, IDLE);
    rst = 1'b0; read_i = 1'b0;
    tick();
    chk("mr_no_resp", resp_o, 0);
    address_i = 32'h0000_4010; read_i = 1'b1;
    tick();
    chk("mr_addr2", mem_if.address_o, 32'h0000_4000);
    for (int k = 0; k < 4; k++) begin
      mem_if.resp_i = 1'b1; mem_if.burst_i = 64'h100 + 64'(k);
      tick();
    end
    mem_if.resp_i = 1'b0;
    chk("mr_resp", resp_o, 1);
    chk("mr_line2", line_o, {64'h103, 64'h102, 64'h101, 64'h100});
    read_i = 1'b0;
    tick();

    // ---- spurious resp_i in IDLE
    mem_if.resp_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("sp_outs", {mem_if.read_o, mem_if.write_o, resp_o}, 3'b000);
    end
    chk("sp_state", dut.state_q, IDLE);
    chk("sp_line_hold", line_o, {64'h103, 64'h102, 64'h101, 64'h100});
    mem_if.resp_i = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
